lif_neuron_param: RTL and testbench
===================================

// Module: lif_neuron_param
// PURPOSE
//  Parametrised integrate-and-fire hidden-layer neuron with writable signed weight RAM.
//  Accumulates addressed synaptic weights per input event; fires when the membrane exceeds THETA.
//  Supports a refractory period counted in timer ticks and a held spike/ack output handshake.
//  One instance per hidden unit. Sits between the input-event router and the output-layer arbiter.
// PARAMETERS
//  W_BIT      8    signed synaptic weight width
//  V_BIT      12   signed membrane potential width (W_BIT < V_BIT <= 16)
//  ADDR_BIT   8    weight address width; depth = 2**ADDR_BIT
//  THETA      320  firing threshold, signed V_BIT; fire when vmem > THETA
//  REFRACTORY 0    refractory length in timer_en ticks (0..15)
//  LEAK_SHIFT 4    leak divisor exponent (used only with LIF_LEAK_EN)
// PORTS
//  clk        in   1         clock
//  resetn     in   1         synchronous active-low reset
//  spike_in   in   1         input event valid
//  addr_in    in   ADDR_BIT  presynaptic index for spike_in
//  timer_en   in   1         global time-step tick
//  w_wr_en    in   1         weight write strobe
//  w_wr_addr  in   ADDR_BIT  weight write address
//  w_wr_data  in   W_BIT     signed weight write data
//  ack_in     in   1         downstream acknowledge of spike_out
//  spike_out  out  1         spike request, held until acknowledged
//  spike_lost out  1         sticky flag: a fire occurred while spike_out was still pending
//  vmem       out  V_BIT     registered membrane potential (debug/observe)
// BEHAVIOUR
//  Reset (resetn==0 at edge): spike_out=0, spike_lost=0, vmem=0, state=INTEG, ref_cnt=0, pipeline valids=0.
//    The weight RAM is not reset.
//  Pipeline (edge k samples spike_in/addr_in):
//    - k+1: synchronous RAM read registered.
//    - k+2: vmem <= sat(vmem + sext(w)).
//    - k+3: fire evaluated from the vmem registered at k+2.
//    Back-to-back inputs are accepted every cycle.
//  Saturation: sums clamp to [-2**(V_BIT-1), 2**(V_BIT-1)-1]. No wrap-around.
//  Write/read same address, same cycle: the read returns old data; the write takes effect next cycle.
//  FSM states: INTEG, REFRACT.
//    INTEG: accumulates. If vmem > THETA at edge: vmem <= 0, spike_out <= 1, and
//      ref_cnt <= REFRACTORY; go to REFRACT if REFRACTORY != 0, else stay in INTEG.
//      An accumulate landing on the fire edge is discarded (vmem=0 wins).
//    REFRACT: accumulate stage suppressed (in-flight and new events discarded); vmem held at 0.
//      Each timer_en decrements ref_cnt; at ref_cnt==1 with timer_en, go to INTEG next edge.
//  Handshake:
//    - spike_out clears on the edge after ack_in is sampled high.
//    - ack_in while spike_out==0 is ignored.
//    - Fire and ack on the same edge: spike_out stays 1 (new spike); spike_lost is unchanged.
//    - Fire while spike_out==1 and no ack: spike_out stays 1, spike_lost <= 1 (sticky until reset).
//  Reset mid-operation aborts the pipeline and refractory period; nothing is flushed out.
// CONFIGURATION
//  LIF_LEAK_EN defined:
//    - In INTEG, on timer_en, vmem update = sat(vmem + w_stage - (vmem >>> LEAK_SHIFT)).
//    - The leak term is taken from the current vmem; it combines with a same-cycle accumulate.
//    - Arithmetic shift, so negative vmem leaks toward 0.
//  LIF_LEAK_EN undefined: no leak logic; timer_en affects only ref_cnt.
// TESTING (THETA=320, V_BIT=12, W_BIT=8, LEAK_SHIFT=4 unless noted)
//  1 Hold resetn=0 for 2 cycles, then release -> spike_out=0, spike_lost=0, vmem=0.
//  2 Write w[5]=100; spike_in addr 5 on 4 consecutive cycles (k..k+3) ->
//    vmem 100/200/300/400 at edges k+2..k+5; spike_out=1 and vmem=0 at edge k+6.
//  3 Keep ack_in=0 for 10 cycles -> spike_out stays 1; pulse ack_in 1 cycle -> spike_out=0 next edge.
//    Second fire while pending -> spike_lost=1.
//  4 REFRACTORY=2: fire, then 3 events w=100 -> vmem stays 0;
//    after 2 timer_en ticks, events accumulate again (vmem=100).
//  5 Write w[9]=-128; 20 events -> vmem clamps at -2048; no wrap or fire.
//    Then w[9]=127 events -> counts up from -2048.
//  6 LIF_LEAK_EN: vmem=160, timer_en with no event -> vmem=150;
//    with a same-cycle event w=20 -> vmem=170. Without the macro -> vmem unchanged on timer_en.

Source files
------------

// File: rtl/lif_neuron_param.sv
// Integrate-and-fire hidden neuron: weight RAM lookup, saturating membrane, refractory FSM, held spike/ack.
// Optional membrane leak on timer_en is compiled in when LIF_LEAK_EN is defined.
module lif_neuron_param #(
  parameter int W_BIT      = 8,
  parameter int V_BIT      = 12,
  parameter int ADDR_BIT   = 8,
  parameter int THETA      = 320,
  parameter int REFRACTORY = 0,
  parameter int LEAK_SHIFT = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       spike_in,
  input  logic [ADDR_BIT-1:0]        addr_in,
  input  logic                       timer_en,
  input  logic                       w_wr_en,
  input  logic [ADDR_BIT-1:0]        w_wr_addr,
  input  logic signed [W_BIT-1:0]    w_wr_data,
  input  logic                       ack_in,
  output logic                       spike_out,
  output logic                       spike_lost,
  output logic signed [V_BIT-1:0]    vmem
);

  if (!(V_BIT > W_BIT && V_BIT <= 16) || REFRACTORY < 0 || REFRACTORY > 15 ||
      LEAK_SHIFT < 0 || LEAK_SHIFT >= V_BIT) begin : g_bad_param
    $error("lif_neuron_param: illegal parameter combination");
  end

  typedef enum logic [0:0] {
    S_INTEG   = 1'b0,
    S_REFRACT = 1'b1
  } state_t;

  localparam logic signed [V_BIT-1:0] L_THETA = V_BIT'(THETA);
  localparam logic signed [V_BIT+1:0] L_VMAX  = (V_BIT+2)'((1 <<< (V_BIT-1)) - 1);
  localparam logic signed [V_BIT+1:0] L_VMIN  = (V_BIT+2)'(-(1 <<< (V_BIT-1)));
  localparam logic [3:0]              L_REF   = 4'(REFRACTORY);

  function automatic logic signed [V_BIT+1:0] sext_v(input logic signed [V_BIT-1:0] x);
    return {{2{x[V_BIT-1]}}, x};
  endfunction

  function automatic logic signed [V_BIT+1:0] sext_w(input logic signed [W_BIT-1:0] x);
    return {{(V_BIT+2-W_BIT){x[W_BIT-1]}}, x};
  endfunction

  function automatic logic signed [V_BIT-1:0] sat_v(input logic signed [V_BIT+1:0] s);
    if (s > L_VMAX)      return L_VMAX[V_BIT-1:0];
    else if (s < L_VMIN) return L_VMIN[V_BIT-1:0];
    else                 return s[V_BIT-1:0];
  endfunction

  logic signed [W_BIT-1:0]  r_mem [2**ADDR_BIT];
  logic [ADDR_BIT-1:0]      r_addr_p0;
  logic                     r_vld_p0;
  logic signed [W_BIT-1:0]  r_w_p1;
  logic                     r_vld_p1;
  logic signed [V_BIT-1:0]  r_vmem;
  logic                     r_spike;
  logic                     r_lost;
  logic [3:0]               r_ref_cnt;
  state_t                   r_state;

  logic                     w_fire;
  logic                     w_upd;
  logic signed [V_BIT+1:0]  w_w_ext;
  logic signed [V_BIT+1:0]  w_leak_ext;
  logic signed [V_BIT-1:0]  w_vmem_nxt;

  // Stage p0: capture event; stage p1: synchronous weight read (old data on same-address write)
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_wr_addr] <= w_wr_data;
    r_addr_p0 <= addr_in;
    r_w_p1    <= r_mem[r_addr_p0];
  end

  assign w_fire  = (r_state == S_INTEG) && (r_vmem > L_THETA);
  assign w_w_ext = r_vld_p1 ? sext_w(r_w_p1) : '0;

`ifdef LIF_LEAK_EN
  logic signed [V_BIT-1:0] w_leak_v;
  assign w_leak_v   = r_vmem >>> LEAK_SHIFT;
  assign w_leak_ext = timer_en ? sext_v(w_leak_v) : '0;
  assign w_upd      = r_vld_p1 || timer_en;
`else
  assign w_leak_ext = '0;
  assign w_upd      = r_vld_p1;
`endif

  assign w_vmem_nxt = sat_v(sext_v(r_vmem) + w_w_ext - w_leak_ext);

  // Stage p2: membrane update, fire decision on the registered membrane, handshake, refractory
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_vld_p0  <= 1'b0;
      r_vld_p1  <= 1'b0;
      r_vmem    <= '0;
      r_spike   <= 1'b0;
      r_lost    <= 1'b0;
      r_ref_cnt <= '0;
      r_state   <= S_INTEG;
    end else begin
      r_vld_p0 <= spike_in;
      r_vld_p1 <= r_vld_p0;

      if (w_fire) begin
        r_spike <= 1'b1;
        if (r_spike && !ack_in) r_lost <= 1'b1;
      end else if (ack_in) begin
        r_spike <= 1'b0;
      end

      case (r_state)
        S_INTEG: begin
          if (w_fire) begin
            r_vmem    <= '0;
            r_ref_cnt <= L_REF;
            if (L_REF != 4'd0) r_state <= S_REFRACT;
          end else if (w_upd) begin
            r_vmem <= w_vmem_nxt;
          end
        end
        S_REFRACT: begin
          r_vmem <= '0;
          if (timer_en) begin
            if (r_ref_cnt == 4'd1) begin
              r_ref_cnt <= '0;
              r_state   <= S_INTEG;
            end else begin
              r_ref_cnt <= r_ref_cnt - 4'd1;
            end
          end
        end
        default: r_state <= S_INTEG;
      endcase
    end
  end

  assign spike_out  = r_spike;
  assign spike_lost = r_lost;
  assign vmem       = r_vmem;

endmodule

// File: tb/tb_lif_neuron_param.sv
// Directed bench for lif_neuron_param: one instance without and one with a 2-tick refractory period.
module tb_lif_neuron_param;

  logic                clk = 1'b0;
  logic                resetn = 1'b0;
  logic                spike_in = 1'b0;
  logic [7:0]          addr_in = '0;
  logic                timer_en = 1'b0;
  logic                w_wr_en = 1'b0;
  logic [7:0]          w_wr_addr = '0;
  logic signed [7:0]   w_wr_data = '0;
  logic                ack_in = 1'b0;

  logic                spike_out, spike_lost;
  logic signed [11:0]  vmem;
  logic                spike_out_r, spike_lost_r;
  logic signed [11:0]  vmem_r;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  lif_neuron_param #(.W_BIT(8), .V_BIT(12), .ADDR_BIT(8), .THETA(320), .REFRACTORY(0), .LEAK_SHIFT(4)) dut (
    .clk(clk), .resetn(resetn), .spike_in(spike_in), .addr_in(addr_in), .timer_en(timer_en),
    .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data), .ack_in(ack_in),
    .spike_out(spike_out), .spike_lost(spike_lost), .vmem(vmem)
  );

  lif_neuron_param #(.W_BIT(8), .V_BIT(12), .ADDR_BIT(8), .THETA(320), .REFRACTORY(2), .LEAK_SHIFT(4)) dut_r (
    .clk(clk), .resetn(resetn), .spike_in(spike_in), .addr_in(addr_in), .timer_en(timer_en),
    .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data), .ack_in(ack_in),
    .spike_out(spike_out_r), .spike_lost(spike_lost_r), .vmem(vmem_r)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(input logic [7:0] a, input logic signed [7:0] d);
    w_wr_en = 1'b1; w_wr_addr = a; w_wr_data = d;
    step();
    w_wr_en = 1'b0;
  endtask

  task automatic burst(input logic [7:0] a, input int n);
    spike_in = 1'b1; addr_in = a;
    steps(n);
    spike_in = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
  endtask

  task automatic chk_v(input string tag, input logic signed [11:0] obs, input int exp_i);
    logic signed [11:0] e;
    e = 12'(exp_i);
    n_tot++;
    assert (obs === e) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, e);
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic e);
    n_tot++;
    assert (obs === e) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, e);
  endtask

  initial begin
    // reset held two cycles
    steps(2);
    chk_b("rst_spike", spike_out, 1'b0);
    chk_b("rst_lost", spike_lost, 1'b0);
    chk_v("rst_vmem", vmem, 0);
    chk_v("rst_vmem_r", vmem_r, 0);
    resetn = 1'b1;

    // accumulate 4 x 100 with pipeline latency, fire on 400
    wr(8'd5, 8'sd100);
    spike_in = 1'b1; addr_in = 8'd5;
    step();
    step();
    step();
    chk_v("acc_k2", vmem, 100);
    step();
    chk_v("acc_k3", vmem, 200);
    spike_in = 1'b0;
    step();
    chk_v("acc_k4", vmem, 300);
    step();
    chk_v("acc_k5", vmem, 400);
    chk_b("nofire_k5", spike_out, 1'b0);
    step();
    chk_b("fire_k6", spike_out, 1'b1);
    chk_v("fire_vmem0", vmem, 0);

    // held until ack; ack clears; ack while idle ignored
    steps(10);
    chk_b("held_10", spike_out, 1'b1);
    ack_in = 1'b1; step(); ack_in = 1'b0;
    chk_b("ack_clear", spike_out, 1'b0);
    ack_in = 1'b1; step(); ack_in = 1'b0;
    chk_b("ack_idle", spike_out, 1'b0);
    chk_b("ack_idle_lost", spike_lost, 1'b0);

    // fresh fire, then fire coinciding with ack
    burst(8'd5, 4); steps(3);
    chk_b("fire2", spike_out, 1'b1);
    chk_b("fire2_lost", spike_lost, 1'b0);
    burst(8'd5, 4); steps(2);
    ack_in = 1'b1; step(); ack_in = 1'b0;
    chk_b("fire_ack_same", spike_out, 1'b1);
    chk_b("fire_ack_lost", spike_lost, 1'b0);

    // fire while pending without ack sets sticky lost flag
    burst(8'd5, 4); steps(3);
    chk_b("pend_spike", spike_out, 1'b1);
    chk_b("pend_lost", spike_lost, 1'b1);
    ack_in = 1'b1; step(); ack_in = 1'b0;
    chk_b("lost_ack_spike", spike_out, 1'b0);
    chk_b("lost_sticky", spike_lost, 1'b1);

    // reset clears flags; refractory instance ignores events for 2 ticks
    do_reset();
    chk_b("rst2_lost", spike_lost, 1'b0);
    chk_v("rst2_vmem", vmem, 0);
    burst(8'd5, 4); steps(3);
    chk_b("ref_fire", spike_out_r, 1'b1);
    chk_v("ref_fire_v", vmem_r, 0);
    burst(8'd5, 3); steps(2);
    chk_v("ref_suppr", vmem_r, 0);
    timer_en = 1'b1; step(); timer_en = 1'b0;
    burst(8'd5, 1); steps(2);
    chk_v("ref_tick1", vmem_r, 0);
    timer_en = 1'b1; step(); timer_en = 1'b0;
    burst(8'd5, 1); steps(2);
    chk_v("ref_resume", vmem_r, 100);

    // negative saturation, then recovery with positive weight
    do_reset();
    wr(8'd9, -8'sd128);
    burst(8'd9, 20); steps(2);
    chk_v("sat_neg", vmem, -2048);
    chk_b("sat_nofire", spike_out, 1'b0);
    wr(8'd9, 8'sd127);
    burst(8'd9, 1); steps(2);
    chk_v("sat_up1", vmem, -1921);
    burst(8'd9, 2); steps(2);
    chk_v("sat_up3", vmem, -1667);

    // leak on timer_en, alone and with a same-cycle accumulate
    do_reset();
    wr(8'd7, 8'sd80);
    wr(8'd3, 8'sd20);
    burst(8'd7, 2); steps(2);
    chk_v("leak_pre", vmem, 160);
    timer_en = 1'b1; step(); timer_en = 1'b0;
`ifdef LIF_LEAK_EN
    chk_v("leak_only", vmem, 150);
`else
    chk_v("noleak_tick", vmem, 160);
`endif
    do_reset();
    burst(8'd7, 2); steps(2);
    chk_v("leak_pre2", vmem, 160);
    burst(8'd3, 1);
    step();
    timer_en = 1'b1; step(); timer_en = 1'b0;
`ifdef LIF_LEAK_EN
    chk_v("leak_acc", vmem, 170);
`else
    chk_v("noleak_acc", vmem, 180);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
